stream_profiler_collector: RTL and testbench
============================================

Name: stream_profiler_collector

Overview:
- Collects final counter snapshots from N_CH stream profiler instances.
- Detects each profiled stream's stop handshake and latches that profiler's four 64-bit counters one cycle later, once they have settled.
- Round-robin arbitrates among channels with pending snapshots.
- Serialises each snapshot as a fixed-length packet on one 64-bit valid/ready/last output stream that feeds the host readback path.

Parameters:
- N_CH, 4, number of profiled streams (1..256).
- CH_W, $clog2(N_CH) with a minimum of 1, channel index width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- tap_valid  in  N_CH  valid of each profiled stream
- tap_ready  in  N_CH  ready of each profiled stream
- tap_last  in  N_CH  last of each profiled stream
- tap_stop  in  N_CH  stop strobe given to each profiler
- handshakes_i  in  N_CH x 64  profiler handshake counters
- starved_i  in  N_CH x 64  profiler starved counters
- stalled_i  in  N_CH x 64  profiler stalled counters
- idle_i  in  N_CH x 64  profiler idle counters
- out_data  out  64  packet beat
- out_valid  out  1  beat valid
- out_last  out  1  final beat of packet
- out_ready  in  1  downstream ready
- overflow_any  out  1  sticky flag: some channel dropped a snapshot

Behaviour:
- Done condition for channel i in cycle T: done[i] = tap_valid[i] & tap_ready[i] & tap_last[i] & tap_stop[i].
- Capture timing:
  - done[i] is registered into cap_req[i] at the end of T.
  - In T+1, cap_req[i] copies channel i's four counters into snap[i] and sets pending[i].
- Overflow: if pending[i] is already 1 at capture, the new snapshot is discarded, snap[i] is unchanged, and ovf_cnt[i] increments. ovf_cnt[i] is 16-bit and saturates at 0xFFFF.
- overflow_any is set on any discard and stays set until reset.
- FSM IDLE:
  - out_valid = 0.
  - If any pending bit is set, grant the first pending index at or after rr_ptr, scanning upward with wrap.
  - Copy snap[g] into the output buffer, clear pending[g], set rr_ptr = (g+1) mod N_CH, then go to SEND with beat = 0.
- FSM SEND:
  - out_valid = 1. out_data = buffer[beat].
  - out_last = 1 only when beat == NBEATS-1.
  - On handshake: beat increments. After the last-beat handshake, go to IDLE.
- Stall and spacing:
  - While out_valid & !out_ready, out_data and out_last hold stable.
  - Packets are always separated by at least one IDLE cycle.
- Grant and capture in the same cycle on the same channel: the capture wins.
  - pending stays 1 and snap takes the new values.
  - The buffer holds the old snapshot.
  - No overflow is counted.
- Latency: done in cycle T -> pending set at end of T+1 -> grant in T+2 -> header beat valid in T+3 when no arbitration contention.
- Packet layout, NBEATS = 5:
  - beat 0, header: [63:56] = 8'hA5; [55:48] = channel index, zero-extended; [47:32] = ovf_cnt[g] sampled at grant; [31:0] = seq.
  - beat 1: handshakes. beat 2: starved. beat 3: stalled. beat 4: idle.
- seq is a 32-bit packet counter. It increments on each last-beat handshake, wraps at 2^32, and resets to 0.
- Multiple simultaneous done pulses are each captured independently.
- Reset (including during a packet):
  - FSM goes to IDLE; out_valid = 0, out_last = 0, out_data = 0.
  - pending, cap_req, rr_ptr, seq, ovf_cnt and overflow_any are all cleared.
  - snap contents are don't-care.
  - Any partial packet is abandoned and never resumed.

Optional Feature:
- Macro: STREAM_PROFILER_TIMESTAMP_EN.
- When defined:
  - A free-running 64-bit cycle counter runs, cleared by reset, incrementing every cycle and wrapping.
  - It is captured into snap[i] alongside the counters in the capture cycle.
  - It is emitted as beat 5, so NBEATS = 6 and out_last moves to beat 5.
- When undefined: no counter logic exists and NBEATS = 5.

Decomposition:
- Shared package:
  - existing data64_t
  - profiler_snapshot_t struct (four data64_t, plus ts when STREAM_PROFILER_TIMESTAMP_EN is defined)
  - PROF_HDR_MAGIC = 8'hA5
  - PROF_NBEATS
  - collector FSM state enum
- Sub-module: rr_arbiter_n.
  - Parameter N; inputs req[N] and ptr.
  - Outputs gnt_valid and gnt_idx; purely combinational.
  - Instantiated once; reusable elsewhere.

Test Plan:
- Single channel: ch0 counters {10,2,3,7}, stop handshake at T, out_ready = 1 -> header valid at T+3 = 0xA5_00_0000_00000000, then beats 10, 2, 3, 7 with out_last on beat 4; seq becomes 1.
- Simultaneous done on ch1 and ch3 with rr_ptr = 0 -> ch1 packet first, then ch3 packet after one IDLE cycle; second header bits [31:0] = 1.
- Backpressure: out_ready toggles 1,0,0,1 during beats -> each beat held stable while stalled; exactly 5 handshakes; no duplicated beats.
- Overflow: two ch2 done pulses while ch2 is pending and the output is stalled -> second discarded; the next ch2 header [47:32] = 1; overflow_any = 1.
- Reset asserted mid-packet after beat 2 -> next cycle out_valid = 0; no residual packet after release; next packet has seq 0 and ovf field 0.
- With STREAM_PROFILER_TIMESTAMP_EN defined: done at cycle 100 after reset -> packet is 6 beats; beat 5 = timestamp value at the capture cycle (101); out_last on beat 5.

Source files
------------

// File: rtl/stream_profiler_collector_pkg.sv
// Shared types and constants for the stream profiler snapshot collector.
// Defining STREAM_PROFILER_TIMESTAMP_EN adds a capture timestamp as a sixth packet beat.
package stream_profiler_collector_pkg;

    typedef logic [63:0] data64_t;

    typedef struct packed {
        data64_t handshakes;
        data64_t starved;
        data64_t stalled;
        data64_t idle;
`ifdef STREAM_PROFILER_TIMESTAMP_EN
        data64_t ts;
`endif
    } profiler_snapshot_t;

    localparam logic [7:0] PROF_HDR_MAGIC = 8'hA5;

`ifdef STREAM_PROFILER_TIMESTAMP_EN
    localparam int PROF_NBEATS = 6;
`else
    localparam int PROF_NBEATS = 5;
`endif

    localparam int PROF_BEAT_W = 3;

    typedef enum logic [0:0] {
        COL_IDLE = 1'b0,
        COL_SEND = 1'b1
    } collector_state_t;

    function automatic data64_t prof_header(input logic [7:0] ch,
                                            input logic [15:0] ovf,
                                            input logic [31:0] seq);
        return {PROF_HDR_MAGIC, ch, ovf, seq};
    endfunction

endpackage

// File: rtl/stream_profiler_collector_rr_arbiter_n.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
// Used by stream_profiler_collector; has no dependency on the collector package.
module rr_arbiter_n #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);

    int         idx;
    logic [W-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            idx  = (int'(ptr) + k) % N;
            cand = W'(idx);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/stream_profiler_collector.sv
// Latches final counters of N_CH stream profilers on their stop handshake and
// serialises each snapshot as a fixed-length packet; optional STREAM_PROFILER_TIMESTAMP_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no packet in flight; grant a pending channel and load buffer
// ST_SEND  | drive buffer[beat]; advance on handshake, back to idle after last
module stream_profiler_collector
    import stream_profiler_collector_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       tap_valid,
    input  logic [N_CH-1:0]       tap_ready,
    input  logic [N_CH-1:0]       tap_last,
    input  logic [N_CH-1:0]       tap_stop,
    input  logic [N_CH-1:0][63:0] handshakes_i,
    input  logic [N_CH-1:0][63:0] starved_i,
    input  logic [N_CH-1:0][63:0] stalled_i,
    input  logic [N_CH-1:0][63:0] idle_i,
    output logic [63:0]           out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  overflow_any
);

    localparam logic [0:0] ST_IDLE = 1'(COL_IDLE);
    localparam logic [0:0] ST_SEND = 1'(COL_SEND);
    localparam logic [PROF_BEAT_W-1:0] LAST_BEAT = PROF_BEAT_W'(PROF_NBEATS - 1);

    logic [0:0]             state;
    logic [PROF_BEAT_W-1:0] beat;
    logic [N_CH-1:0]        done;
    logic [N_CH-1:0]        cap_req;
    logic [N_CH-1:0]        pending;
    logic [N_CH-1:0]        grant_hit;
    logic [N_CH-1:0]        cap_drop;
    logic [N_CH-1:0]        cap_take;
    logic [CH_W-1:0]        rr_ptr;
    logic [31:0]            seq;
    logic [15:0]            ovf_cnt [N_CH];
    profiler_snapshot_t     snap    [N_CH];
    data64_t                pkt_buf [PROF_NBEATS];

    logic                   gnt_valid;
    logic [CH_W-1:0]        gnt_idx;
    logic                   grant;
    logic [7:0]             gnt_ch8;
    logic                   last_hs;

`ifdef STREAM_PROFILER_TIMESTAMP_EN
    logic [63:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + 64'd1;
    end
`endif

    assign done = tap_valid & tap_ready & tap_last & tap_stop;

    rr_arbiter_n #(.N(N_CH)) u_arb (
        .req       (pending),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign grant   = (state == ST_IDLE) && gnt_valid;
    assign last_hs = (state == ST_SEND) && out_ready && (beat == LAST_BEAT);

    // A capture landing on the channel being granted refills it rather than overflowing.
    always_comb begin
        grant_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant_hit[i] = grant && (gnt_idx == CH_W'(i));
        end
        cap_drop = cap_req & pending & ~grant_hit;
        cap_take = cap_req & ~cap_drop;
    end

    always_comb begin
        gnt_ch8              = '0;
        gnt_ch8[CH_W-1:0]    = gnt_idx;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (cap_take[i]) begin
                snap[i].handshakes <= handshakes_i[i];
                snap[i].starved    <= starved_i[i];
                snap[i].stalled    <= stalled_i[i];
                snap[i].idle       <= idle_i[i];
`ifdef STREAM_PROFILER_TIMESTAMP_EN
                snap[i].ts         <= ts_cnt;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            pkt_buf[0] <= prof_header(gnt_ch8, ovf_cnt[gnt_idx], seq);
            pkt_buf[1] <= snap[gnt_idx].handshakes;
            pkt_buf[2] <= snap[gnt_idx].starved;
            pkt_buf[3] <= snap[gnt_idx].stalled;
            pkt_buf[4] <= snap[gnt_idx].idle;
`ifdef STREAM_PROFILER_TIMESTAMP_EN
            pkt_buf[5] <= snap[gnt_idx].ts;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_req      <= '0;
            pending      <= '0;
            overflow_any <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ovf_cnt[i] <= '0;
            end
        end else begin
            cap_req <= done;
            if (|cap_drop) overflow_any <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (grant_hit[i]) pending[i] <= 1'b0;
                if (cap_take[i])  pending[i] <= 1'b1;
                if (cap_drop[i] && (ovf_cnt[i] != 16'hFFFF)) begin
                    ovf_cnt[i] <= ovf_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            beat   <= '0;
            rr_ptr <= '0;
            seq    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state  <= ST_SEND;
                        beat   <= '0;
                        rr_ptr <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (beat == LAST_BEAT) begin
                            state <= ST_IDLE;
                            seq   <= seq + 32'd1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (state == ST_SEND);
    assign out_last  = (state == ST_SEND) && (beat == LAST_BEAT);
    assign out_data  = (state == ST_SEND) ? pkt_buf[beat] : '0;

endmodule

// File: tb/tb_stream_profiler_collector.sv
// Directed self-checking bench for stream_profiler_collector (N_CH = 4).
module tb_stream_profiler_collector;
    import stream_profiler_collector_pkg::*;

    localparam int N = 4;
`ifdef STREAM_PROFILER_TIMESTAMP_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         tap_valid, tap_ready, tap_last, tap_stop;
    logic [N-1:0][63:0]   handshakes_i, starved_i, stalled_i, idle_i;
    logic [63:0]          out_data;
    logic                 out_valid, out_last, out_ready, overflow_any;

    int                   checks = 0;
    int                   errors = 0;
    logic [63:0]          exp_beats [6];
    bit                   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int                   hs;
    bit                   seen_valid;

    always #5 clk = ~clk;

    stream_profiler_collector #(.N_CH(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .tap_valid    (tap_valid),
        .tap_ready    (tap_ready),
        .tap_last     (tap_last),
        .tap_stop     (tap_stop),
        .handshakes_i (handshakes_i),
        .starved_i    (starved_i),
        .stalled_i    (stalled_i),
        .idle_i       (idle_i),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .overflow_any (overflow_any)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_counters(input int ch, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] c, input logic [63:0] d);
        handshakes_i[ch] = a;
        starved_i[ch]    = b;
        stalled_i[ch]    = c;
        idle_i[ch]       = d;
    endtask

    task automatic set_exp(input logic [63:0] h, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [63:0] d);
        exp_beats[0] = h;
        exp_beats[1] = a;
        exp_beats[2] = b;
        exp_beats[3] = c;
        exp_beats[4] = d;
        exp_beats[5] = '0;
    endtask

    // Drives a done pulse during the current cycle; returns one cycle later.
    task automatic pulse_done(input logic [N-1:0] mask);
        tap_valid = mask;
        tap_ready = mask;
        tap_last  = mask;
        tap_stop  = mask;
        tick();
        tap_valid = '0;
        tap_ready = '0;
        tap_last  = '0;
        tap_stop  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        chk({tag, "_valid"}, out_valid, 1'b1);
    endtask

    task automatic read_packet(input string tag, input bit chk_ts);
        wait_valid(tag);
        out_ready = 1'b1;
        for (int b = 0; b < NB; b++) begin
            if (b < 5 || chk_ts) chk($sformatf("%s_b%0d", tag, b), out_data, exp_beats[b]);
            chk($sformatf("%s_last%0d", tag, b), out_last, (b == NB - 1));
            tick();
        end
        chk({tag, "_gap"}, out_valid, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        tap_valid    = '0;
        tap_ready    = '0;
        tap_last     = '0;
        tap_stop     = '0;
        handshakes_i = '0;
        starved_i    = '0;
        stalled_i    = '0;
        idle_i       = '0;
        out_ready    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_data", out_data, 64'h0);
        chk("rst_ovf", overflow_any, 1'b0);

        // Single channel, latency to header
        out_ready = 1'b1;
        set_counters(0, 64'd10, 64'd2, 64'd3, 64'd7);
        pulse_done(4'b0001);
        chk("t1_lat1", out_valid, 1'b0);
        tick();
        chk("t1_lat2", out_valid, 1'b0);
        tick();
        chk("t1_lat3", out_valid, 1'b1);
        set_exp(64'hA500_0000_0000_0000, 64'd10, 64'd2, 64'd3, 64'd7);
        read_packet("t1", 1'b0);

        // Simultaneous done on ch1 and ch3 from a fresh rr_ptr
        do_reset();
        set_counters(1, 64'd11, 64'd12, 64'd13, 64'd14);
        set_counters(3, 64'd31, 64'd32, 64'd33, 64'd34);
        pulse_done(4'b1010);
        set_exp(64'hA501_0000_0000_0000, 64'd11, 64'd12, 64'd13, 64'd14);
        read_packet("t2a", 1'b0);
        set_exp(64'hA503_0000_0000_0001, 64'd31, 64'd32, 64'd33, 64'd34);
        read_packet("t2b", 1'b0);

        // Backpressure with ready pattern 1,0,0,1
        set_counters(2, 64'd21, 64'd22, 64'd23, 64'd24);
        set_exp(64'hA502_0000_0000_0002, 64'd21, 64'd22, 64'd23, 64'd24);
        pulse_done(4'b0100);
        wait_valid("t3");
        hs = 0;
        for (int c = 0; c < 40 && hs < NB; c++) begin
            out_ready = pat[c % 4];
            if (hs < 5) chk($sformatf("t3_data_c%0d", c), out_data, exp_beats[hs]);
            chk($sformatf("t3_last_c%0d", c), out_last, (hs == NB - 1));
            if (out_ready) hs++;
            tick();
        end
        chk("t3_hs", 64'(hs), 64'(NB));
        chk("t3_gap", out_valid, 1'b0);

        // Overflow on ch2 while the output is stalled on a ch0 packet
        out_ready = 1'b0;
        pulse_done(4'b0001);
        tick();
        tick();
        chk("t4_hold_valid", out_valid, 1'b1);
        set_counters(2, 64'd41, 64'd42, 64'd43, 64'd44);
        pulse_done(4'b0100);
        tick();
        set_counters(2, 64'd51, 64'd52, 64'd53, 64'd54);
        pulse_done(4'b0100);
        tick();
        chk("t4_ovf_any", overflow_any, 1'b1);
        chk("t4_hold_data", out_data, 64'hA500_0000_0000_0003);
        set_exp(64'hA500_0000_0000_0003, 64'd10, 64'd2, 64'd3, 64'd7);
        read_packet("t4a", 1'b0);
        set_exp(64'hA502_0001_0000_0004, 64'd41, 64'd42, 64'd43, 64'd44);
        read_packet("t4b", 1'b0);
        chk("t4_ovf_sticky", overflow_any, 1'b1);

        // Reset in the middle of a packet
        out_ready = 1'b1;
        set_exp(64'hA501_0000_0000_0005, 64'd11, 64'd12, 64'd13, 64'd14);
        pulse_done(4'b0010);
        wait_valid("t5");
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("t5_pre_b%0d", b), out_data, exp_beats[b]);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", out_valid, 1'b0);
        chk("t5_last", out_last, 1'b0);
        chk("t5_data", out_data, 64'h0);
        chk("t5_ovf_any", overflow_any, 1'b0);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen_valid = 1'b1;
            tick();
        end
        chk("t5_no_residue", seen_valid, 1'b0);
        pulse_done(4'b0100);
        set_exp(64'hA502_0000_0000_0000, 64'd51, 64'd52, 64'd53, 64'd54);
        read_packet("t5b", 1'b0);

`ifdef STREAM_PROFILER_TIMESTAMP_EN
        // Timestamp beat: done in cycle 100 after reset, captured in cycle 101
        do_reset();
        repeat (100) tick();
        set_counters(0, 64'd1, 64'd2, 64'd3, 64'd4);
        pulse_done(4'b0001);
        set_exp(64'hA500_0000_0000_0000, 64'd1, 64'd2, 64'd3, 64'd4);
        exp_beats[5] = 64'd101;
        read_packet("t6", 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
